// File: rtl/decimal_input_entry_pkg.sv
// ============================================================================
// Module      : decimal_input_entry_pkg
// Description : Shared types and default parameters for the decimal keypad
//               entry block (state enumeration, debounce length, digit limit).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package decimal_input_entry_pkg;

  // 10 ms of stable level at a 50 MHz system clock
  localparam int DEFAULT_DEBOUNCE_CYCLES = 500000;
  // 8 decimal digits always fit in 32 bits unsigned
  localparam int DEFAULT_MAX_DIGITS      = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ENTRY = 2'd1,
    READY = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/decimal_input_entry_if.sv
// ============================================================================
// Module      : decimal_input_entry_if
// Description : CPU-side handshake between an input instruction and the
//               keypad entry block.
// Ports       : FLAG_input  - CPU requests a value (master -> slave)
//               data_ack    - one-cycle consume pulse (master -> slave)
//               IO_input    - latched two's-complement value (slave -> master)
//               data_ready  - IO_input valid until acknowledged (slave -> master)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface decimal_input_entry_if;
  logic        FLAG_input;
  logic        data_ack;
  logic [31:0] IO_input;
  logic        data_ready;

  modport master (
    output FLAG_input,
    output data_ack,
    input  IO_input,
    input  data_ready
  );

  modport slave (
    input  FLAG_input,
    input  data_ack,
    output IO_input,
    output data_ready
  );
endinterface

`default_nettype wire

// File: rtl/decimal_input_entry_key_debouncer.sv
// ============================================================================
// Module      : key_debouncer
// Description : 2-flop synchronizer, stable-level debouncer and press-pulse
//               generator for one raw active-low push button.
// Ports       : clock    - system clock
//               reset    - synchronous active-low reset
//               key_n_i  - raw bouncing active-low key
//               press_o  - one-cycle pulse on accepted 1->0 transition
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module key_debouncer
  import decimal_input_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  wire logic clock,
  input  wire logic reset,
  input  wire logic key_n_i,
  output logic      press_o
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             stable_q;
  logic             stable_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic             press_q;

  // The counter tracks how many consecutive cycles the synchronized level has
  // disagreed with the stable level; any agreeing cycle restarts the run.
  always_comb begin
    stable_d = stable_q;
    cnt_d    = '0;
    if (sync2_q != stable_q) begin
      if (cnt_q == CNT_LAST) begin
        stable_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      sync1_q  <= 1'b1;
      sync2_q  <= 1'b1;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync1_q  <= key_n_i;
      sync2_q  <= sync1_q;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      // Only the falling edge of the stable level is a press
      press_q  <= stable_q & ~stable_d;
    end
  end

  assign press_o = press_q;

endmodule

`default_nettype wire

// File: rtl/decimal_input_entry.sv
// ============================================================================
// Module      : decimal_input_entry
// Description : Decimal keypad entry for a CPU input instruction. Debounced
//               digit/enter/clear keys build an unsigned magnitude which is
//               latched as a signed two's-complement value on enter.
// Ports       : clock, reset      - system clock, sync active-low reset
//               digit_sw, sign_sw - BCD digit and sign switches
//               key_digit/enter/clear - raw active-low push buttons
//               bus (slave)       - FLAG_input/data_ack/IO_input/data_ready
//               entry_value       - running unsigned magnitude
//               digit_count       - digits accepted in current entry
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module decimal_input_entry
  import decimal_input_entry_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
  parameter int MAX_DIGITS      = DEFAULT_MAX_DIGITS
) (
  input  wire logic           clock,
  input  wire logic           reset,
  input  wire logic [3:0]     digit_sw,
  input  wire logic           sign_sw,
  input  wire logic           key_digit,
  input  wire logic           key_enter,
  input  wire logic           key_clear,
  decimal_input_entry_if.slave bus,
  output logic [31:0]         entry_value,
  output logic [3:0]          digit_count
);

  localparam logic [3:0] MAX_D = 4'(MAX_DIGITS);

  logic        dig_ev;
  logic        ent_ev;
  logic        clr_ev;

  state_t      state_q;
  logic [31:0] entry_value_q;
  logic [3:0]  digit_count_q;
  logic [31:0] io_q;
  logic        ready_q;

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_digit (
    .clock   (clock),
    .reset   (reset),
    .key_n_i (key_digit),
    .press_o (dig_ev)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_enter (
    .clock   (clock),
    .reset   (reset),
    .key_n_i (key_enter),
    .press_o (ent_ev)
  );

  key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_clear (
    .clock   (clock),
    .reset   (reset),
    .key_n_i (key_clear),
    .press_o (clr_ev)
  );

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q       <= IDLE;
      entry_value_q <= '0;
      digit_count_q <= '0;
      io_q          <= '0;
      ready_q       <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.FLAG_input) begin
            state_q       <= ENTRY;
            entry_value_q <= '0;
            digit_count_q <= '0;
          end
        end
        ENTRY: begin
          // Losing the request abandons the entry before any key is honoured
          if (!bus.FLAG_input) begin
            state_q       <= IDLE;
            entry_value_q <= '0;
            digit_count_q <= '0;
          end else if (clr_ev) begin
            entry_value_q <= '0;
            digit_count_q <= '0;
          end else if (ent_ev) begin
            // Two's-complement negate; a zero magnitude stays zero
            io_q    <= sign_sw ? (~entry_value_q + 32'd1) : entry_value_q;
            ready_q <= 1'b1;
            state_q <= READY;
          end else if (dig_ev && (digit_sw <= 4'd9) && (digit_count_q < MAX_D)) begin
            entry_value_q <= (entry_value_q * 32'd10) + {28'd0, digit_sw};
            digit_count_q <= digit_count_q + 4'd1;
          end
        end
        READY: begin
          if (bus.data_ack) begin
            ready_q <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.IO_input   = io_q;
  assign bus.data_ready = ready_q;
  assign entry_value    = entry_value_q;
  assign digit_count    = digit_count_q;

endmodule

`default_nettype wire

// File: tb/tb_decimal_input_entry.sv
// ============================================================================
// Module      : tb_decimal_input_entry
// Description : Self-checking bench for decimal_input_entry. Keys are pressed
//               long enough to pass the debouncer; a value-level model of the
//               entry (magnitude, digit count, signed result) predicts outputs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_decimal_input_entry;
  import decimal_input_entry_pkg::*;

  localparam int DEB  = 4;
  localparam int MAXD = 8;
  localparam int HOLD = 12;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  digit_sw;
  logic        sign_sw;
  logic        key_digit;
  logic        key_enter;
  logic        key_clear;
  logic [31:0] entry_value;
  logic [3:0]  digit_count;

  decimal_input_entry_if bus ();

  decimal_input_entry #(
    .DEBOUNCE_CYCLES (DEB),
    .MAX_DIGITS      (MAXD)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .digit_sw    (digit_sw),
    .sign_sw     (sign_sw),
    .key_digit   (key_digit),
    .key_enter   (key_enter),
    .key_clear   (key_clear),
    .bus         (bus),
    .entry_value (entry_value),
    .digit_count (digit_count)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_err = 0;

  // Reference model: the entry as a number and a digit tally
  longint unsigned m_val;
  int              m_cnt;
  logic [31:0]     m_io;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expd);
    n_chk++;
    if (obs !== expd) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, expd);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // which: 0 = digit, 1 = enter, 2 = clear
  task automatic press(input int which);
    case (which)
      0: key_digit = 1'b0;
      1: key_enter = 1'b0;
      default: key_clear = 1'b0;
    endcase
    tick(HOLD);
    key_digit = 1'b1;
    key_enter = 1'b1;
    key_clear = 1'b1;
    tick(HOLD);
  endtask

  task automatic check_entry(input string tag);
    chk({tag, "_val"}, entry_value, 32'(m_val));
    chk({tag, "_cnt"}, {28'd0, digit_count}, 32'(m_cnt));
  endtask

  task automatic start_entry();
    bus.FLAG_input = 1'b1;
    tick(2);
    m_val = 0;
    m_cnt = 0;
    check_entry("start");
    chk("start_state", 32'(dut.state_q), 32'(ENTRY));
  endtask

  task automatic do_digit(input logic [3:0] d);
    digit_sw = d;
    press(0);
    if (d <= 9 && m_cnt < MAXD) begin
      m_val = m_val * 10 + d;
      m_cnt++;
    end
    check_entry("digit");
  endtask

  task automatic do_clear();
    press(2);
    m_val = 0;
    m_cnt = 0;
    check_entry("clear");
  endtask

  task automatic do_enter(input logic s);
    longint signed v;
    sign_sw = s;
    press(1);
    v    = s ? -longint'(m_val) : longint'(m_val);
    m_io = v[31:0];
    chk("enter_ready", {31'd0, bus.data_ready}, 32'd1);
    chk("enter_io", bus.IO_input, m_io);
  endtask

  task automatic do_ack();
    bus.data_ack = 1'b1;
    tick(1);
    bus.data_ack = 1'b0;
    chk("ack_ready", {31'd0, bus.data_ready}, 32'd0);
    chk("ack_io", bus.IO_input, m_io);
    chk("ack_state", 32'(dut.state_q), 32'(IDLE));
  endtask

  initial begin
    reset        = 1'b0;
    digit_sw     = 4'd0;
    sign_sw      = 1'b0;
    key_digit    = 1'b1;
    key_enter    = 1'b1;
    key_clear    = 1'b1;
    bus.FLAG_input = 1'b0;
    bus.data_ack   = 1'b0;
    m_val = 0;
    m_cnt = 0;
    m_io  = 32'd0;
    tick(3);
    chk("rst_io", bus.IO_input, 32'd0);
    chk("rst_ready", {31'd0, bus.data_ready}, 32'd0);
    check_entry("rst");
    chk("rst_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b1;
    tick(2);

    // -123
    start_entry();
    do_digit(4'd1);
    do_digit(4'd2);
    do_digit(4'd3);
    do_enter(1'b1);
    chk("neg123", bus.IO_input, 32'hFFFFFF85);
    do_ack();

    // Bouncing key: short lows then a long low gives one event
    start_entry();
    digit_sw = 4'd6;
    key_digit = 1'b0; tick(2);
    key_digit = 1'b1; tick(2);
    key_digit = 1'b0; tick(3);
    key_digit = 1'b1; tick(1);
    key_digit = 1'b0; tick(10);
    key_digit = 1'b1; tick(HOLD);
    chk("bounce_cnt", {28'd0, digit_count}, 32'd1);
    chk("bounce_val", entry_value, 32'd6);
    // data_ack outside READY is ignored
    bus.data_ack = 1'b1; tick(1); bus.data_ack = 1'b0;
    chk("ack_in_entry", 32'(dut.state_q), 32'(ENTRY));
    m_val = 6; m_cnt = 1;
    do_enter(1'b0);
    do_ack();

    // Digit limit
    start_entry();
    for (int i = 0; i < 9; i++) do_digit(4'd9);
    chk("max_val", entry_value, 32'd99999999);
    do_enter(1'b0);
    chk("max_io", bus.IO_input, 32'd99999999);
    do_ack();

    // Clear, out-of-range digit, keys ignored in READY
    start_entry();
    do_digit(4'd5);
    do_clear();
    do_digit(4'd7);
    do_digit(4'hA);
    do_enter(1'b0);
    chk("seven_io", bus.IO_input, 32'd7);
    digit_sw = 4'd3;
    press(0);
    chk("ready_hold", {31'd0, bus.data_ready}, 32'd1);
    chk("ready_io", bus.IO_input, 32'd7);
    do_ack();

    // Negative zero
    start_entry();
    do_enter(1'b1);
    chk("negzero", bus.IO_input, 32'd0);
    do_ack();

    // Abort on FLAG_input drop
    start_entry();
    do_digit(4'd4);
    do_digit(4'd2);
    bus.FLAG_input = 1'b0;
    tick(2);
    chk("abort_state", 32'(dut.state_q), 32'(IDLE));
    start_entry();

    // Randomized entries
    for (int t = 0; t < 6; t++) begin
      int n;
      start_entry();
      n = $urandom_range(0, 10);
      for (int k = 0; k < n; k++) begin
        if ($urandom_range(0, 9) == 0) do_clear();
        else do_digit(4'($urandom_range(0, 11)));
      end
      do_enter(1'($urandom_range(0, 1)));
      do_ack();
    end

    // Reset while READY
    start_entry();
    do_digit(4'd4);
    do_enter(1'b0);
    reset = 1'b0;
    tick(1);
    chk("rstr_ready", {31'd0, bus.data_ready}, 32'd0);
    chk("rstr_io", bus.IO_input, 32'd0);
    chk("rstr_state", 32'(dut.state_q), 32'(IDLE));
    reset = 1'b1;
    bus.FLAG_input = 1'b1;
    tick(20);
    chk("rstr_noev", {28'd0, digit_count}, 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

`default_nettype wire
